// File: rtl/fft_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctl_pkg
// Brief    : Shared types and constant helpers for the radix-4 SDF FFT
//            pipeline sequencer (state encoding, stage thresholds, widths).
// Revision : 1.0 - initial release
// ============================================================================
package fft_ctl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } ctl_state_t;

    // Number of advance cycles before stage s sees valid data.
    // Stage j holds 3/4 of its block size in the feedback delay line, and
    // every stage boundary adds pipe_lat register stages.
    function automatic int thresh(input int log4n, input int pipe_lat, input int s);
        int t;
        int n;
        t = 0;
        n = 1 << (2 * log4n);
        for (int j = 0; j < s; j++) begin
            t = t + 3 * ((n >> (2 * j)) / 4) + pipe_lat;
        end
        return t;
    endfunction

    // Fill counter width: enough to hold the output latency T_S itself
    function automatic int cnt_w(input int log4n, input int pipe_lat);
        return $clog2(thresh(log4n, pipe_lat, log4n) + 1);
    endfunction

endpackage : fft_ctl_pkg
`default_nettype wire

// File: rtl/fft_ctl_thresh.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctl_thresh
// Brief    : Comparator bank turning the saturating fill count into the
//            per-stage enables and the output-valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module fft_ctl_thresh
    import fft_ctl_pkg::*;
#(
    parameter int LOG4_N   = 4,
    parameter int PIPE_LAT = 1,
    parameter int CW       = cnt_w(LOG4_N, PIPE_LAT)
) (
    input  logic [CW-1:0]     fill_cnt,
    input  logic              adv,
    output logic [LOG4_N-1:0] stage_en,
    output logic              out_valid
);

    localparam logic [CW-1:0] c_TS = CW'(thresh(LOG4_N, PIPE_LAT, LOG4_N));

    generate
        for (genvar s = 0; s < LOG4_N; s++) begin : g_stage
            if (s == 0) begin : g_first
                // The first stage has no upstream delay: it runs on every advance
                assign stage_en[s] = adv;
            end else begin : g_rest
                localparam logic [CW-1:0] c_T = CW'(thresh(LOG4_N, PIPE_LAT, s));
                // Stage s runs once its input delay line has been filled
                assign stage_en[s] = adv & (fill_cnt >= c_T);
            end
        end
    endgenerate

    // The last stage produces real results once the full latency has elapsed
    assign out_valid = adv & (fill_cnt >= c_TS);

endmodule : fft_ctl_thresh
`default_nettype wire

// File: rtl/fft_pipe_ctl.sv
`default_nettype none
// ============================================================================
// Module   : fft_pipe_ctl
// Brief    : Sequencer for a radix-4 single-delay-feedback FFT pipeline of
//            N = 4^LOG4_N points. Counts accepted samples, enables stages as
//            their delay lines fill and tags output samples.
//            Optional zero-padding flush: define FFT_CTL_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fft_pipe_ctl
    import fft_ctl_pkg::*;
#(
    parameter int LOG4_N   = 4,
    parameter int PIPE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LOG4_N-1:0]     stage_en,
    output logic [2*LOG4_N-1:0]   in_index,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic [2*LOG4_N-1:0]   out_index,
    output logic                  busy
`ifdef FFT_CTL_FLUSH_EN
    ,
    input  logic                  flush,
    output logic                  in_zero
`endif
);

    localparam int c_IW = 2 * LOG4_N;
    localparam int c_N  = 1 << c_IW;
    localparam int c_TS = thresh(LOG4_N, PIPE_LAT, LOG4_N);
    localparam int c_CW = cnt_w(LOG4_N, PIPE_LAT);
    localparam logic [c_CW-1:0] c_TS_CNT = c_CW'(c_TS);

    ctl_state_t         r_state;
    logic [c_CW-1:0]    r_fill_cnt;
    logic [c_IW-1:0]    r_in_index;
    logic [c_IW-1:0]    r_out_index;
    logic               w_flushing;
    logic               w_adv;
    logic               w_out_valid;

`ifdef FFT_CTL_FLUSH_EN
    // Padding length covers the rest of the input frame plus the drain latency
    localparam int c_REM_W = $clog2(c_N + c_TS + 1);
    logic [c_REM_W-1:0] r_flush_rem;
    logic [c_IW-1:0]    w_in_next;
    logic [c_IW-1:0]    w_pad;

    // Flush length is taken from the index the frame will have after this cycle
    always_comb begin
        w_in_next = w_adv ? r_in_index + c_IW'(1) : r_in_index;
        w_pad     = -w_in_next;
    end

    assign w_flushing = (r_state == FLUSH);
    assign in_zero    = w_flushing;
`else
    assign w_flushing = 1'b0;
`endif

    // Source is held off during reset and while zeros are being padded in
    assign in_ready = ~rst & ~w_flushing;
    // A pipeline advance is a real accepted sample or a padding cycle
    assign w_adv    = ~rst & ((in_valid & in_ready) | w_flushing);

    fft_ctl_thresh #(
        .LOG4_N   (LOG4_N),
        .PIPE_LAT (PIPE_LAT),
        .CW       (c_CW)
    ) u_thresh (
        .fill_cnt  (r_fill_cnt),
        .adv       (w_adv),
        .stage_en  (stage_en),
        .out_valid (w_out_valid)
    );

    assign out_valid = w_out_valid;
    assign out_sof   = w_out_valid & (r_out_index == '0);
    assign in_index  = r_in_index;
    assign out_index = r_out_index;
    assign busy      = (r_state != IDLE);

    // Counters and state machine; later assignments in FLUSH clear the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fill_cnt  <= '0;
            r_in_index  <= '0;
            r_out_index <= '0;
`ifdef FFT_CTL_FLUSH_EN
            r_flush_rem <= '0;
`endif
        end else begin
            if (w_adv) begin
                if (r_fill_cnt != c_TS_CNT) begin
                    r_fill_cnt <= r_fill_cnt + c_CW'(1);
                end
                r_in_index <= r_in_index + c_IW'(1);
            end
            if (w_out_valid) begin
                r_out_index <= r_out_index + c_IW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_adv) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (r_fill_cnt == c_TS_CNT) begin
                        r_state <= RUN;
                    end
`ifdef FFT_CTL_FLUSH_EN
                    if (flush) begin
                        r_state     <= FLUSH;
                        r_flush_rem <= c_REM_W'(w_pad) + c_REM_W'(c_TS);
                    end
`endif
                end
                RUN: begin
`ifdef FFT_CTL_FLUSH_EN
                    if (flush) begin
                        r_state     <= FLUSH;
                        r_flush_rem <= c_REM_W'(w_pad) + c_REM_W'(c_TS);
                    end
`endif
                end
`ifdef FFT_CTL_FLUSH_EN
                FLUSH: begin
                    r_flush_rem <= r_flush_rem - c_REM_W'(1);
                    if (r_flush_rem == c_REM_W'(1)) begin
                        r_state     <= IDLE;
                        r_fill_cnt  <= '0;
                        r_in_index  <= '0;
                        r_out_index <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : fft_pipe_ctl
`default_nettype wire

// File: tb/tb_fft_pipe_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_pipe_ctl
// Brief    : Directed self-checking bench for fft_pipe_ctl, default
//            configuration (N=256, PIPE_LAT=1) plus a LOG4_N=3, PIPE_LAT=2
//            instance. Flush scenario active when FFT_CTL_FLUSH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_pipe_ctl;

    logic       clk;
    int         n_vec;
    int         n_err;

    // Default-parameter instance
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] stage_en;
    logic [7:0] in_index;
    logic       out_valid;
    logic       out_sof;
    logic [7:0] out_index;
    logic       busy;

    // LOG4_N=3, PIPE_LAT=2 instance
    logic       rst_s;
    logic       in_valid_s;
    logic       in_ready_s;
    logic [2:0] stage_en_s;
    logic [5:0] in_index_s;
    logic       out_valid_s;
    logic       out_sof_s;
    logic [5:0] out_index_s;
    logic       busy_s;

`ifdef FFT_CTL_FLUSH_EN
    logic       flush;
    logic       in_zero;
    logic       flush_s;
    logic       in_zero_s;
`endif

    fft_pipe_ctl u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stage_en  (stage_en),
        .in_index  (in_index),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_index (out_index),
        .busy      (busy)
`ifdef FFT_CTL_FLUSH_EN
        ,
        .flush     (flush),
        .in_zero   (in_zero)
`endif
    );

    fft_pipe_ctl #(
        .LOG4_N   (3),
        .PIPE_LAT (2)
    ) u_dut_s (
        .clk       (clk),
        .rst       (rst_s),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .stage_en  (stage_en_s),
        .in_index  (in_index_s),
        .out_valid (out_valid_s),
        .out_sof   (out_sof_s),
        .out_index (out_index_s),
        .busy      (busy_s)
`ifdef FFT_CTL_FLUSH_EN
        ,
        .flush     (flush_s),
        .in_zero   (in_zero_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {stage_en, out_valid, out_sof, in_index, out_index, busy} for
    // the k-th accepted sample of a stall-free frame, N=256, T = 0,193,242,255,259
    function automatic logic [22:0] exp_big(input int k);
        logic [3:0] en;
        logic       ov;
        logic       sof;
        logic [7:0] ii;
        logic [7:0] oi;
        logic       b;
        en  = {k >= 255, k >= 242, k >= 193, 1'b1};
        ov  = (k >= 259);
        sof = ov && (((k - 259) % 256) == 0);
        ii  = 8'(k % 256);
        oi  = ov ? 8'((k - 259) % 256) : 8'd0;
        b   = (k > 0);
        return {en, ov, sof, ii, oi, b};
    endfunction

    // Same for N=64, T = 0,50,64,69
    function automatic logic [17:0] exp_small(input int k);
        logic [2:0] en;
        logic       ov;
        logic       sof;
        logic [5:0] ii;
        logic [5:0] oi;
        logic       b;
        en  = {k >= 64, k >= 50, 1'b1};
        ov  = (k >= 69);
        sof = ov && (((k - 69) % 64) == 0);
        ii  = 6'(k % 64);
        oi  = ov ? 6'((k - 69) % 64) : 6'd0;
        b   = (k > 0);
        return {en, ov, sof, ii, oi, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        #1;
        n_vec++;
        if ({in_ready, stage_en, out_valid, out_sof, busy} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_hold got %b exp 00000000", {in_ready, stage_en, out_valid, out_sof, busy});
        end
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, stage_en, out_valid, out_sof, in_index, out_index, busy} !== {1'b1, 23'h0}) begin
            n_err++;
            $display("FAIL reset_after got %h exp %h",
                     {in_ready, stage_en, out_valid, out_sof, in_index, out_index, busy}, {1'b1, 23'h0});
        end
        tick();
    endtask

    // 2000 back-to-back samples: threshold edges, saturation, index wrap
    task automatic test_fill_run();
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            in_valid = 1'b1;
            #1;
            n_vec++;
            if ({stage_en, out_valid, out_sof, in_index, out_index, busy} !== exp_big(k)) begin
                n_err++;
                $display("FAIL fill_run k=%0d got %h exp %h", k,
                         {stage_en, out_valid, out_sof, in_index, out_index, busy}, exp_big(k));
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // 10-cycle gap at k=200: everything idles and holds, thresholds shift
    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 270; k++) begin
            if (k == 200) begin
                for (int g = 0; g < 10; g++) begin
                    in_valid = 1'b0;
                    #1;
                    n_vec++;
                    if ({stage_en, out_valid, out_sof, in_index, out_index, busy} !== {6'h00, 8'd200, 8'd0, 1'b1}) begin
                        n_err++;
                        $display("FAIL stall_gap g=%0d got %h exp %h", g,
                                 {stage_en, out_valid, out_sof, in_index, out_index, busy},
                                 {6'h00, 8'd200, 8'd0, 1'b1});
                    end
                    tick();
                end
            end
            in_valid = 1'b1;
            #1;
            n_vec++;
            if ({stage_en, out_valid, out_sof, in_index, out_index, busy} !== exp_big(k)) begin
                n_err++;
                $display("FAIL stall_run k=%0d got %h exp %h", k,
                         {stage_en, out_valid, out_sof, in_index, out_index, busy}, exp_big(k));
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // One-cycle reset at k=300 restarts the frame and the fill latency
    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, stage_en, out_valid} !== 6'h00) begin
            n_err++;
            $display("FAIL midrst_hold got %b exp 000000", {in_ready, stage_en, out_valid});
        end
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if ({stage_en, out_valid, out_sof, in_index, out_index, busy} !== 23'h0) begin
            n_err++;
            $display("FAIL midrst_after got %h exp 000000",
                     {stage_en, out_valid, out_sof, in_index, out_index, busy});
        end
        tick();
        for (int k = 0; k < 262; k++) begin
            in_valid = 1'b1;
            #1;
            n_vec++;
            if ({stage_en, out_valid, out_sof, in_index, out_index, busy} !== exp_big(k)) begin
                n_err++;
                $display("FAIL midrst_run k=%0d got %h exp %h", k,
                         {stage_en, out_valid, out_sof, in_index, out_index, busy}, exp_big(k));
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

`ifdef FFT_CTL_FLUSH_EN
    // Flush at in_index=100 in RUN: 156+259 padding cycles ending on index 255
    task automatic test_flush();
        int         cyc;
        logic [7:0] last_oi;
        logic       last_ov;
        do_reset();
        for (int k = 0; k < 356; k++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, in_zero, in_index} !== {2'b10, 8'd100}) begin
            n_err++;
            $display("FAIL flush_req got %h exp %h", {in_ready, in_zero, in_index}, {2'b10, 8'd100});
        end
        tick();
        flush   = 1'b0;
        cyc     = 0;
        last_oi = 8'd0;
        last_ov = 1'b0;
        while (in_zero === 1'b1 && cyc < 1000) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL flush_ready cyc=%0d got %b exp 0", cyc, in_ready);
            end
            last_oi = out_index;
            last_ov = out_valid;
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 415) begin
            n_err++;
            $display("FAIL flush_len got %0d exp 415", cyc);
        end
        n_vec++;
        if ({last_ov, last_oi} !== {1'b1, 8'd255}) begin
            n_err++;
            $display("FAIL flush_last got %h exp %h", {last_ov, last_oi}, {1'b1, 8'd255});
        end
        #1;
        n_vec++;
        if ({busy, in_ready, in_index, out_index} !== {2'b01, 16'h0}) begin
            n_err++;
            $display("FAIL flush_idle got %h exp %h", {busy, in_ready, in_index, out_index}, {2'b01, 16'h0});
        end
        tick();
    endtask
`endif

    // Smaller pipeline: T = 0,50,64,69, frame period 64
    task automatic test_small();
        rst_s      = 1'b1;
        in_valid_s = 1'b0;
        tick();
        tick();
        rst_s = 1'b0;
        for (int k = 0; k < 220; k++) begin
            in_valid_s = 1'b1;
            #1;
            n_vec++;
            if ({stage_en_s, out_valid_s, out_sof_s, in_index_s, out_index_s, busy_s} !== exp_small(k)) begin
                n_err++;
                $display("FAIL small_run k=%0d got %h exp %h", k,
                         {stage_en_s, out_valid_s, out_sof_s, in_index_s, out_index_s, busy_s}, exp_small(k));
            end
            tick();
        end
        in_valid_s = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        rst_s      = 1'b1;
        in_valid_s = 1'b0;
`ifdef FFT_CTL_FLUSH_EN
        flush      = 1'b0;
        flush_s    = 1'b0;
`endif
        #1;
        test_reset();
        test_fill_run();
        test_stall();
        test_mid_reset();
`ifdef FFT_CTL_FLUSH_EN
        test_flush();
`endif
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fft_pipe_ctl
`default_nettype wire
